elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//  Request scheduler and motion/door sequencer for the elevator car. It latches hall-button
//  presses, chooses the next target with a direction-preserving (SCAN) policy, and times travel
//  between floors and door dwell. It drives the per-floor request LEDs, the one-hot floor
//  indication, door and moving. It sits directly behind the button pins inside TOP.
// PARAMETERS
//  N_FLOORS      3           number of floors, index 0 = ground; min 2
//  TICK_DIV      25_000_000  clk_50 cycles per timing tick
//  TRAVEL_TICKS  4           ticks to travel one floor
//  DOOR_TICKS    6           ticks the door stays open
// PORTS
//  clk_50    in   1         system clock, all logic on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  button_n  in   N_FLOORS  hall buttons, active-low, asynchronous to clk_50
//  led       out  N_FLOORS  1 = request pending for that floor
//  floor     out  N_FLOORS  one-hot current/last-departed floor
//  door      out  1         1 = door open
//  moving    out  1         1 = car travelling
//  dir_up    out  1         current/last travel direction, 1 = up
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - req=0 (led=0), floor=1 (bit 0), door=0, moving=0, dir_up=1.
//   - State IDLE; prescaler, tick counter and synchronisers cleared (synchronisers to 1 = released).
//  Input path:
//   - Each button_n goes through a 2-FF synchroniser, then a falling-edge detect.
//   - press[i] is a 1-cycle pulse. led[i] rises on the 3rd rising edge after button_n[i] is first sampled low.
//   - A low level shorter than 2 clk_50 periods is not guaranteed to be captured. Holding a button generates a single press.
//  Timebase:
//   - Prescaler counts 0..TICK_DIV-1. tick=1 for one cycle at TICK_DIV-1.
//   - Prescaler and tick counter clear on every state change and every floor change.
//   - Result: a travel leg lasts exactly TRAVEL_TICKS*TICK_DIV cycles; a dwell lasts exactly DOOR_TICKS*TICK_DIV cycles.
//  Request latch:
//   - press[i] sets req[i], except in IDLE or DOOR_OPEN when i == current floor: no latch; the press opens/extends the door.
//   - While moving, a press for the departed floor latches normally.
//   - Simultaneous presses all latch. req[i] clears only on the edge where the car enters DOOR_OPEN at floor i.
//  Helpers: above = |req above floor; below = |req below floor.
//  FSM:
//   IDLE       door=0, moving=0; one-cycle decision, priority order:
//              a) press or req at current floor -> DOOR_OPEN
//              b) above & (dir_up | ~below)      -> MOVE_UP, dir_up=1
//              c) below                          -> MOVE_DOWN, dir_up=0
//              d) else stay IDLE
//   MOVE_UP /  moving=1, door=0.
//   MOVE_DOWN  - On the TRAVEL_TICKS-th tick, floor shifts one position (left for up, right for down).
//              - Same edge: if req at the new floor -> DOOR_OPEN, moving=0, req bit cleared.
//              - Otherwise remain in MOVE (a request beyond exists by construction).
//              - Never shifts past bit 0 or bit N_FLOORS-1.
//   DOOR_OPEN  door=1, moving=0.
//              - A press at the current floor restarts the dwell (prescaler and count cleared).
//              - On the DOOR_TICKS-th tick -> IDLE (door=0).
//  Invariants:
//   - floor is always one-hot.
//   - door & moving is never 1.
//   - dir_up changes only on IDLE->MOVE.
//  Reset mid-operation: all outputs go to reset values immediately; pending requests are lost.
// TESTING  (TICK_DIV=4, TRAVEL_TICKS=2, DOOR_TICKS=3, N_FLOORS=3)
//  1. Reset: assert rst_n=0 mid-cycle -> led=000, floor=001, door=0, moving=0, dir_up=1 with no clock edge.
//  2. Hold button_n[2] low 3 cycles from IDLE at floor 0:
//     - led=100 after 3 edges; moving=1, dir_up=1 one cycle later.
//     - floor=010 after 8 cycles in MOVE, floor=100 after 16 cycles.
//     - Same edge as floor=100: door=1, moving=0, led=000. door=0 after 12 more cycles.
//  3. Press at current floor in IDLE:
//     - door=1 for 12 cycles, led unchanged.
//     - Re-press at cycle 8 of dwell -> door stays 1 for 12 cycles after the re-press.
//  4. From floor 0, request floor 2; press floor 1 during the first leg:
//     - Stop at floor=010 with door=1 and led=100 only.
//     - After dwell, travel up to floor 2.
//  5. At floor 2 IDLE with dir_up=1, request floor 0 -> MOVE_DOWN, dir_up=0, arrive at floor=001 after 16 cycles.
//  6. Press buttons 1 and 2 in the same cycle at floor 0:
//     - led=110.
//     - Doors open at floor 1 then floor 2.
//     - door & moving never both 1.

Source files
------------

// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator scheduler: latches hall presses, picks direction, times travel legs and door dwell.
// Button-to-led latency 3 clk_50 edges; outputs decode state directly, no backpressure.
module elevator_scheduler #(
    parameter int N_FLOORS     = 3,
    parameter int TICK_DIV     = 25_000_000,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 6
) (
    input  logic                clk_50,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] button_n,
    output logic [N_FLOORS-1:0] led,
    output logic [N_FLOORS-1:0] floor,
    output logic                door,
    output logic                moving,
    output logic                dir_up
);
    localparam int PW   = $clog2(TICK_DIV + 1);
    localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW   = $clog2(MAXT + 1);
    localparam logic [PW-1:0]       PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]       TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0]       DOOR_LAST   = TW'(DOOR_TICKS - 1);
    localparam logic [N_FLOORS-1:0] ONE         = N_FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
    state_t state, state_nxt;

    logic [N_FLOORS-1:0] sync1, sync2, sync_prev, press;
    logic [N_FLOORS-1:0] req, req_nxt, floor_nxt;
    logic [PW-1:0]       presc;
    logic [TW-1:0]       tcnt;
    logic dir_nxt, tick, last_tick, restart, tmr_clr;
    logic above, below, req_here, press_here;

    // Synchronisers idle at 1 so a button held through reset is not seen as a press.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            sync_prev <= '1;
        end else begin
            sync1     <= button_n;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign press      = sync_prev & ~sync2;
    assign tick       = (presc == PRESC_LAST);
    assign last_tick  = tick && (tcnt == ((state == DOOR_OPEN) ? DOOR_LAST : TRAVEL_LAST));
    assign req_here   = |(req & floor);
    assign press_here = |(press & floor);
    assign below      = |(req & (floor - ONE));
    assign above      = |(req & ~(floor | (floor - ONE)));

    always_comb begin
        state_nxt = state;
        floor_nxt = floor;
        dir_nxt   = dir_up;
        restart   = 1'b0;
        req_nxt   = req | press;
        case (state)
            IDLE: begin
                req_nxt = req | (press & ~floor);
                if (press_here || req_here) begin
                    state_nxt = DOOR_OPEN;
                end else if (above && (dir_up || !below)) begin
                    state_nxt = MOVE_UP;
                    dir_nxt   = 1'b1;
                end else if (below) begin
                    state_nxt = MOVE_DOWN;
                    dir_nxt   = 1'b0;
                end
            end
            MOVE_UP: begin
                if (last_tick && !floor[N_FLOORS-1]) begin
                    floor_nxt = floor << 1;
                    if (|(req & floor_nxt)) state_nxt = DOOR_OPEN;
                end
            end
            MOVE_DOWN: begin
                if (last_tick && !floor[0]) begin
                    floor_nxt = floor >> 1;
                    if (|(req & floor_nxt)) state_nxt = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                req_nxt = req | (press & ~floor);
                if (press_here)     restart   = 1'b1;
                else if (last_tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Serving a floor retires its request on the same edge the door opens.
        if (state_nxt == DOOR_OPEN && state != DOOR_OPEN) req_nxt = req_nxt & ~floor_nxt;
        tmr_clr = restart || (state_nxt != state) || (floor_nxt != floor);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req    <= '0;
            floor  <= ONE;
            dir_up <= 1'b1;
            presc  <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_nxt;
            req    <= req_nxt;
            floor  <= floor_nxt;
            dir_up <= dir_nxt;
            if (tmr_clr) begin
                presc <= '0;
                tcnt  <= '0;
            end else if (tick) begin
                presc <= '0;
                tcnt  <= last_tick ? '0 : tcnt + TW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign led    = req;
    assign door   = (state == DOOR_OPEN);
    assign moving = (state == MOVE_UP) || (state == MOVE_DOWN);
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a short timebase (4 cycles/tick, 2 travel ticks, 3 door ticks).
module tb_elevator_scheduler;
    logic       clk_50;
    logic       rst_n;
    logic [2:0] button_n;
    logic [2:0] led;
    logic [2:0] floor;
    logic       door;
    logic       moving;
    logic       dir_up;

    int vectors = 0;
    int errs    = 0;

    elevator_scheduler #(
        .N_FLOORS    (3),
        .TICK_DIV    (4),
        .TRAVEL_TICKS(2),
        .DOOR_TICKS  (3)
    ) dut (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .button_n(button_n),
        .led     (led),
        .floor   (floor),
        .door    (door),
        .moving  (moving),
        .dir_up  (dir_up)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic chkv(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each, and check the invariants every cycle.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50);
            #1;
            chkb("door_and_moving", door & moving, 1'b0);
            chkb("floor_onehot", $onehot(floor), 1'b1);
        end
    endtask

    // Two-cycle press; the latching edge is the next one after return.
    task automatic press(input int i);
        button_n[i] = 1'b0;
        step(2);
        button_n = 3'b111;
    endtask

    initial begin
        rst_n    = 1'b1;
        button_n = 3'b111;

        // Async reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chkv("rst_led", led, 3'b000);
        chkv("rst_floor", floor, 3'b001);
        chkb("rst_door", door, 1'b0);
        chkb("rst_moving", moving, 1'b0);
        chkb("rst_dir", dir_up, 1'b1);
        repeat (2) @(posedge clk_50);
        #1 rst_n = 1'b1;

        // Floor 0 -> floor 2, button held 3 cycles
        button_n[2] = 1'b0;
        step(2);
        chkv("t2_led_early", led, 3'b000);
        step(1);
        button_n = 3'b111;
        chkv("t2_led", led, 3'b100);
        chkb("t2_not_moving_yet", moving, 1'b0);
        step(1);
        chkb("t2_moving", moving, 1'b1);
        chkb("t2_dir", dir_up, 1'b1);
        step(7);
        chkv("t2_floor_before_leg", floor, 3'b001);
        step(1);
        chkv("t2_floor1", floor, 3'b010);
        step(7);
        chkv("t2_floor1_hold", floor, 3'b010);
        chkb("t2_moving_hold", moving, 1'b1);
        step(1);
        chkv("t2_floor2", floor, 3'b100);
        chkb("t2_door_open", door, 1'b1);
        chkb("t2_stopped", moving, 1'b0);
        chkv("t2_led_clear", led, 3'b000);
        step(11);
        chkb("t2_door_still", door, 1'b1);
        step(1);
        chkb("t2_door_closed", door, 1'b0);

        // Press at current floor in IDLE, then re-press during dwell
        press(2);
        step(1);
        chkb("t3_door", door, 1'b1);
        chkv("t3_led", led, 3'b000);
        step(5);
        press(2);
        step(1);
        chkb("t3_repress_door", door, 1'b1);
        step(4);
        chkb("t3_extended", door, 1'b1);
        step(7);
        chkb("t3_ext_last", door, 1'b1);
        step(1);
        chkb("t3_closed", door, 1'b0);
        chkv("t3_led_end", led, 3'b000);

        // Floor 2 with dir_up=1, request floor 0
        press(0);
        step(1);
        chkv("t5_led", led, 3'b001);
        chkb("t5_idle", moving, 1'b0);
        step(1);
        chkb("t5_moving", moving, 1'b1);
        chkb("t5_dir_down", dir_up, 1'b0);
        step(8);
        chkv("t5_floor1", floor, 3'b010);
        chkb("t5_passes", moving, 1'b1);
        chkb("t5_no_door", door, 1'b0);
        step(8);
        chkv("t5_floor0", floor, 3'b001);
        chkb("t5_door", door, 1'b1);
        chkv("t5_led_clear", led, 3'b000);
        step(12);
        chkb("t5_closed", door, 1'b0);

        // Request floor 2, then floor 1 during the first leg
        press(2);
        step(2);
        chkb("t4_moving", moving, 1'b1);
        chkb("t4_dir_up", dir_up, 1'b1);
        step(2);
        press(1);
        step(1);
        chkv("t4_led_both", led, 3'b110);
        step(3);
        chkv("t4_stop_floor1", floor, 3'b010);
        chkb("t4_door1", door, 1'b1);
        chkb("t4_stopped", moving, 1'b0);
        chkv("t4_led_left", led, 3'b100);
        step(12);
        chkb("t4_door1_closed", door, 1'b0);
        chkb("t4_idle", moving, 1'b0);
        step(1);
        chkb("t4_resume", moving, 1'b1);
        chkb("t4_resume_dir", dir_up, 1'b1);
        step(8);
        chkv("t4_floor2", floor, 3'b100);
        chkb("t4_door2", door, 1'b1);
        chkv("t4_led_done", led, 3'b000);
        step(12);
        chkb("t4_door2_closed", door, 1'b0);

        // Reset mid-travel: everything returns to reset values without a clock edge
        press(0);
        step(2);
        chkb("mr_moving", moving, 1'b1);
        chkv("mr_led", led, 3'b001);
        #3 rst_n = 1'b0;
        #1;
        chkv("mr_rst_led", led, 3'b000);
        chkv("mr_rst_floor", floor, 3'b001);
        chkb("mr_rst_moving", moving, 1'b0);
        chkb("mr_rst_dir", dir_up, 1'b1);
        chkb("mr_rst_door", door, 1'b0);
        @(posedge clk_50);
        #1 rst_n = 1'b1;

        // Simultaneous presses for floors 1 and 2 from floor 0
        button_n = 3'b001;
        step(2);
        button_n = 3'b111;
        step(1);
        chkv("t6_led", led, 3'b110);
        chkb("t6_door_shut", door, 1'b0);
        step(1);
        chkb("t6_moving", moving, 1'b1);
        chkb("t6_dir", dir_up, 1'b1);
        step(8);
        chkv("t6_floor1", floor, 3'b010);
        chkb("t6_door1", door, 1'b1);
        chkv("t6_led1", led, 3'b100);
        step(12);
        chkb("t6_door1_closed", door, 1'b0);
        step(1);
        chkb("t6_resume", moving, 1'b1);
        step(8);
        chkv("t6_floor2", floor, 3'b100);
        chkb("t6_door2", door, 1'b1);
        chkv("t6_led2", led, 3'b000);
        step(12);
        chkb("t6_door2_closed", door, 1'b0);
        chkb("t6_idle", moving, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
